gshared_sbox_layer: RTL and testbench

// - 2-share, first-order masked layer of NSB parallel uBlock G-component S-boxes (4-bit each).
// - Applies G to the shared state ITER times: one register stage per application.
// - Guard bits refresh each application; a clocked FSM with a valid/ready handshake sequences it.
// - Sits between the key-add/state register and the linear layer of the masked uBlock datapath.

---
 rtl/gshared_sbox_layer.sv | 114 +++++++++++
 tb/tb_gshared_sbox_layer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gshared_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module : gshared_sbox_layer
// Brief  : 2-share first-order masked layer of NSB uBlock G S-boxes, ITER
//          registered applications per accepted input, valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module gshared_sbox_layer #(
  parameter int NSB  = 16,
  parameter int ITER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*NSB-1:0] in_sh0,
  input  logic [4*NSB-1:0] in_sh1,
  input  logic [2*NSB-1:0] guards,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*NSB-1:0] out_sh0,
  output logic [4*NSB-1:0] out_sh1,
  output logic             busy
);

  localparam int CW = $clog2(ITER + 1);
  localparam logic [CW-1:0] c_iter = CW'(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic            w_accept, w_load;
  logic [4*NSB-1:0] w_x0, w_x1;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_load    = w_accept || (r_state == RUN);
  assign w_cnt_inc = r_cnt + CW'(1);

  // Fresh input on accept, otherwise feed back the compressed shares
  assign w_x0 = w_accept ? in_sh0 : out_sh0;
  assign w_x1 = w_accept ? in_sh1 : out_sh1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: w_state_nxt = IDLE;
      RUN:  begin
        w_cnt_nxt = w_cnt_inc;
        if (w_cnt_inc == c_iter) w_state_nxt = DONE;
      end
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) begin
      w_cnt_nxt   = CW'(1);
      w_state_nxt = (ITER == 1) ? DONE : RUN;
    end
  end

  for (genvar k = 0; k < NSB; k++) begin : g_sbox
    logic w_a0, w_b0, w_c0, w_d0, w_a1, w_b1, w_c1, w_d1, w_ra, w_rb;
    logic [1:0] r_e, r_h;
    logic [3:0] r_f, r_g;

    assign {w_d0, w_c0, w_b0, w_a0} = w_x0[4*k +: 4];
    assign {w_d1, w_c1, w_b1, w_a1} = w_x1[4*k +: 4];
    assign {w_rb, w_ra}             = guards[2*k +: 2];

    // Each component sees at most one share index per variable
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_e <= '0;
        r_h <= '0;
        r_f <= '0;
        r_g <= '0;
      end else if (w_load) begin
        r_e <= {w_a1, w_a0};
        r_h <= {w_c1 ^ w_d0, w_c1 ^ w_d1};
        r_f <= {(w_a1 & w_d1) ^ w_a1 ^ w_b1 ^ w_d1 ^ w_ra,
                (w_a1 & w_d0) ^ w_d0 ^ w_ra,
                (w_a0 & w_d1) ^ w_a0 ^ w_b0 ^ w_ra,
                (w_a0 & w_d0) ^ w_ra};
        r_g <= {(w_a1 & w_b1) ^ w_c1 ^ w_d1 ^ w_rb,
                (w_a1 & w_b0) ^ w_c0 ^ w_rb,
                (w_a0 & w_b1) ^ w_d1 ^ w_rb,
                (w_a0 & w_b0) ^ 1'b1 ^ w_rb};
      end
    end

    assign out_sh0[4*k +: 4] = {r_h[0], r_g[0] ^ r_g[1], r_f[0] ^ r_f[1], r_e[0]};
    assign out_sh1[4*k +: 4] = {r_h[1], r_g[2] ^ r_g[3], r_f[2] ^ r_f[3], r_e[1]};
  end

endmodule
`default_nettype wire

// File: tb/tb_gshared_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module : tb_gshared_sbox_layer
// Brief  : Scoreboard bench for gshared_sbox_layer at ITER = 1, 2 and 3.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gshared_sbox_layer;

  localparam int NSB = 16;
  localparam int W   = 4 * NSB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid [3];
  logic out_ready [3];
  logic in_ready [3];
  logic out_valid [3];
  logic busy [3];
  logic [W-1:0] in_sh0 [3];
  logic [W-1:0] in_sh1 [3];
  logic [W-1:0] out_sh0 [3];
  logic [W-1:0] out_sh1 [3];
  logic [2*NSB-1:0] guards = '0;
  logic g_fixed = 1'b0;

  logic [W-1:0] exp_q [$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    gshared_sbox_layer #(.NSB(NSB), .ITER(i + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .in_sh0    (in_sh0[i]),
      .in_sh1    (in_sh1[i]),
      .guards    (guards),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i]),
      .out_sh0   (out_sh0[i]),
      .out_sh1   (out_sh1[i]),
      .busy      (busy[i])
    );
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!g_fixed) guards = $urandom;
    end
  end

  function automatic logic [3:0] g4(input logic [3:0] x);
    logic a, b, c, d;
    {d, c, b, a} = x;
    return {d, (a & b) ^ c ^ 1'b1, (a & d) ^ a ^ b ^ d, a};
  endfunction

  function automatic logic [W-1:0] gn(input logic [W-1:0] x, input int n);
    logic [W-1:0] y;
    y = x;
    for (int r = 0; r < n; r++)
      for (int k = 0; k < NSB; k++) y[4*k +: 4] = g4(y[4*k +: 4]);
    return y;
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle on instance i; scoreboard push on accept, pop on output
  task automatic cycle(input int i, input logic v, input logic [W-1:0] x,
                       input logic [W-1:0] m, input logic rdy, input string tag);
    in_valid[i]  = v;
    in_sh0[i]    = x ^ m;
    in_sh1[i]    = m;
    out_ready[i] = rdy;
    #1;
    if (v && in_ready[i]) exp_q.push_back(gn(x, i + 1));
    if (out_valid[i] && rdy) begin
      if (exp_q.size() != 0) check(tag, out_sh0[i] ^ out_sh1[i], exp_q.pop_front());
      else check({tag, "_unexpected_valid"}, W'(out_valid[i]), '0);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int i);
    for (int t = 0; t < 8 && out_valid[i]; t++) cycle(i, 1'b0, '0, '0, 1'b1, "drain");
    check("drain_idle", W'(busy[i]), '0);
    check("drain_queue_empty", W'(exp_q.size()), '0);
  endtask

  initial begin
    logic [W-1:0] hold0, hold1, x, m, ua, ub;

    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_sh0[i] = '0; in_sh1[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", W'(in_ready[i]), W'(1));
      check("rst_out_valid", W'(out_valid[i]), '0);
      check("rst_busy", W'(busy[i]), '0);
      check("rst_out_sh", out_sh0[i] | out_sh1[i], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // ITER=1: all-zero input, shares 0x5/0x5
    cycle(0, 1'b1, '0, {NSB{4'h5}}, 1'b0, "t1_acc0");
    check("t1_lat_valid", W'(out_valid[0]), W'(1));
    check("t1_zero_const", out_sh0[0] ^ out_sh1[0], {NSB{4'h4}});
    cycle(0, 1'b0, '0, '0, 1'b1, "t1_pop0");
    // all-ones input, shares 0x3/0xC
    cycle(0, 1'b1, {NSB{4'hF}}, {NSB{4'hC}}, 1'b0, "t1_accF");
    check("t1_ones_const", out_sh0[0] ^ out_sh1[0], {NSB{4'hD}});
    cycle(0, 1'b0, '0, '0, 1'b1, "t1_popF");
    check("t1_back_idle", W'(busy[0]), '0);

    for (int n = 0; n < 1000; n++)
      cycle(0, 1'($urandom_range(0, 1)), rand64(), rand64(), 1'($urandom_range(0, 1)), "t1_rand");
    drain(0);

    // ITER=2: two-cycle latency, input ignored while running
    cycle(1, 1'b1, '0, rand64(), 1'b0, "t2_acc");
    check("t2_busy", W'(busy[1]), W'(1));
    check("t2_not_valid", W'(out_valid[1]), '0);
    check("t2_run_not_ready", W'(in_ready[1]), '0);
    cycle(1, 1'b1, {NSB{4'hF}}, rand64(), 1'b0, "t2_run_in");
    check("t2_lat_valid", W'(out_valid[1]), W'(1));
    check("t2_const", out_sh0[1] ^ out_sh1[1], '0);
    cycle(1, 1'b0, '0, '0, 1'b1, "t2_pop");
    drain(1);

    // ITER=1 stall in DONE then back-to-back pop plus accept
    x = rand64();
    cycle(0, 1'b1, x, rand64(), 1'b0, "t3_acc");
    hold0 = out_sh0[0];
    hold1 = out_sh1[0];
    for (int n = 0; n < 5; n++) begin
      cycle(0, 1'b0, rand64(), rand64(), 1'b0, "t3_stall");
      check("t3_stall_valid", W'(out_valid[0]), W'(1));
      check("t3_stall_sh0", out_sh0[0], hold0);
      check("t3_stall_sh1", out_sh1[0], hold1);
    end
    cycle(0, 1'b1, rand64(), rand64(), 1'b1, "t3_b2b_a");
    check("t3_b2b_valid_a", W'(out_valid[0]), W'(1));
    cycle(0, 1'b1, rand64(), rand64(), 1'b1, "t3_b2b_b");
    check("t3_b2b_valid_b", W'(out_valid[0]), W'(1));
    drain(0);

    // ITER=3: reset in the middle of RUN discards the result
    cycle(2, 1'b1, rand64(), rand64(), 1'b0, "t4_acc");
    cycle(2, 1'b0, '0, '0, 1'b0, "t4_run");
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", W'(out_valid[2]), '0);
    check("t4_rst_busy", W'(busy[2]), '0);
    check("t4_rst_ready", W'(in_ready[2]), W'(1));
    check("t4_rst_sh", out_sh0[2] | out_sh1[2], '0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    x = rand64();
    cycle(2, 1'b1, x, rand64(), 1'b0, "t4_acc2");
    check("t4_lat1", W'(out_valid[2]), '0);
    cycle(2, 1'b0, '0, '0, 1'b0, "t4_r1");
    check("t4_lat2", W'(out_valid[2]), '0);
    cycle(2, 1'b0, '0, '0, 1'b0, "t4_r2");
    check("t4_lat3", W'(out_valid[2]), W'(1));
    check("t4_fresh", out_sh0[2] ^ out_sh1[2], gn(x, 3));
    cycle(2, 1'b0, '0, '0, 1'b1, "t4_pop");
    drain(2);

    // Same input and shares with all-zero then all-one guards
    x = rand64();
    m = rand64();
    g_fixed = 1'b1;
    guards = '0;
    cycle(0, 1'b1, x, m, 1'b0, "t5_acc0");
    ua = out_sh0[0] ^ out_sh1[0];
    cycle(0, 1'b0, '0, '0, 1'b1, "t5_pop0");
    guards = '1;
    cycle(0, 1'b1, x, m, 1'b0, "t5_acc1");
    ub = out_sh0[0] ^ out_sh1[0];
    cycle(0, 1'b0, '0, '0, 1'b1, "t5_pop1");
    g_fixed = 1'b0;
    check("t5_guard_invariant", ub, ua);
    check("t5_guard_model", ub, gn(x, 1));
    drain(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
